srl_fifo_status_oreg: RTL and testbench

//  Parametrised SRL-based FIFO for inter-task streams in the quantised linear-layer dataflow (PE/loader/drainer links).

---
 rtl/srl_fifo_status_oreg_if.sv | 32 +++
 rtl/srl_fifo_status_oreg.sv | 90 +++++++++
 tb/tb_srl_fifo_status_oreg.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/srl_fifo_status_oreg_if.sv
// Stream handshake and status bundle for srl_fifo_status_oreg.
// The producer/consumer side holds the master modport and the FIFO holds the slave modport.
interface srl_fifo_status_oreg_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic [ADDR_WIDTH+1:0] if_num_data_valid;
  logic                  if_almost_full;
  logic                  if_almost_empty;
  logic                  err_overflow;
  logic                  err_underflow;

  modport master (
    output if_write_ce, if_write, if_din, if_read_ce, if_read,
    input  if_full_n, if_dout, if_empty_n, if_num_data_valid,
           if_almost_full, if_almost_empty, err_overflow, err_underflow
  );

  modport slave (
    input  if_write_ce, if_write, if_din, if_read_ce, if_read,
    output if_full_n, if_dout, if_empty_n, if_num_data_valid,
           if_almost_full, if_almost_empty, err_overflow, err_underflow
  );
endinterface

// File: rtl/srl_fifo_status_oreg.sv
// SRL-based stream FIFO with registered status flags, an optional output-register head stage
// (capacity DEPTH+1), and sticky overflow/underflow flags.
module srl_fifo_status_oreg #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int OUT_REG    = 0,
  parameter int AF_TH      = 12,
  parameter int AE_TH      = 2
) (
  input logic                   clk,
  input logic                   reset,
  srl_fifo_status_oreg_if.slave bus
);
  localparam int SW   = ADDR_WIDTH + 1;
  localparam int CW   = ADDR_WIDTH + 2;
  localparam bit OREG = (OUT_REG != 0);

  if (DEPTH > (1 << ADDR_WIDTH) || AE_TH >= AF_TH || DEPTH < 2) begin : g_bad_params
    $error("srl_fifo_status_oreg: bad DEPTH/ADDR_WIDTH or AE_TH >= AF_TH");
  end

  logic [DATA_WIDTH-1:0] srl [DEPTH];
  logic [SW-1:0]         srl_cnt, srl_cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  oval, oval_nxt;
  logic [DATA_WIDTH-1:0] odata;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  full_n, empty_n, afull, aempty, ovf, unf;
  logic                  wr, rd, ld, pop;

  assign wr   = bus.if_write & bus.if_write_ce & full_n;
  assign rd   = bus.if_read & bus.if_read_ce & empty_n;
  assign addr = (srl_cnt == '0) ? '0 : ADDR_WIDTH'(srl_cnt - SW'(1));
  assign ld   = OREG & (srl_cnt != '0) & (~oval | rd);
  // With the head register, the SRL only gives up a word when the register takes it.
  assign pop  = OREG ? ld : rd;

  always_comb begin
    oval_nxt = oval;
    if (ld)      oval_nxt = 1'b1;
    else if (rd) oval_nxt = 1'b0;
    srl_cnt_nxt = srl_cnt;
    if (wr & ~pop)      srl_cnt_nxt = srl_cnt + SW'(1);
    else if (pop & ~wr) srl_cnt_nxt = srl_cnt - SW'(1);
    cnt_nxt = CW'(srl_cnt_nxt) + CW'(oval_nxt);
  end

  // Storage has no reset; only the counters decide what is valid.
  always_ff @(posedge clk) begin
    if (wr) begin
      srl[0] <= bus.if_din;
      for (int i = 1; i < DEPTH; i++) srl[i] <= srl[i-1];
    end
    if (ld) odata <= srl[addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      srl_cnt <= '0;
      oval    <= 1'b0;
      cnt     <= '0;
      full_n  <= 1'b1;
      empty_n <= 1'b0;
      afull   <= 1'b0;
      aempty  <= 1'b1;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      srl_cnt <= srl_cnt_nxt;
      oval    <= oval_nxt;
      cnt     <= cnt_nxt;
      full_n  <= (srl_cnt_nxt != SW'(DEPTH));
      empty_n <= OREG ? oval_nxt : (srl_cnt_nxt != '0);
      afull   <= (cnt_nxt >= CW'(AF_TH));
      aempty  <= (cnt_nxt <= CW'(AE_TH));
      ovf     <= ovf | (bus.if_write & bus.if_write_ce & ~full_n);
      unf     <= unf | (bus.if_read & bus.if_read_ce & ~empty_n);
    end
  end

  assign bus.if_dout           = OREG ? odata : srl[addr];
  assign bus.if_full_n         = full_n;
  assign bus.if_empty_n        = empty_n;
  assign bus.if_num_data_valid = cnt;
  assign bus.if_almost_full    = afull;
  assign bus.if_almost_empty   = aempty;
  assign bus.err_overflow      = ovf;
  assign bus.err_underflow     = unf;
endmodule

// File: tb/tb_srl_fifo_status_oreg.sv
// Bench: two FIFOs (OUT_REG=0 and OUT_REG=1) share one stimulus stream; each is checked against
// a table of hand-derived vectors and against a queue-level model of its own.
module tb_srl_fifo_status_oreg;
  localparam int DW = 8, AW = 2, DEPTH = 4, AF = 3, AE = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          write, write_ce, read, read_ce;
  logic [DW-1:0] din;

  srl_fifo_status_oreg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
  srl_fifo_status_oreg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();

  assign b0.if_write = write;  assign b0.if_write_ce = write_ce;  assign b0.if_din = din;
  assign b0.if_read  = read;   assign b0.if_read_ce  = read_ce;
  assign b1.if_write = write;  assign b1.if_write_ce = write_ce;  assign b1.if_din = din;
  assign b1.if_read  = read;   assign b1.if_read_ce  = read_ce;

  srl_fifo_status_oreg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUT_REG(0),
                         .AF_TH(AF), .AE_TH(AE)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  srl_fifo_status_oreg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUT_REG(1),
                         .AF_TH(AF), .AE_TH(AE)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

  logic [1:0]    o_full_n, o_empty_n, o_af, o_ae, o_ovf, o_unf;
  logic [3:0]    o_cnt  [2];
  logic [DW-1:0] o_dout [2];
  assign o_full_n  = {b1.if_full_n, b0.if_full_n};
  assign o_empty_n = {b1.if_empty_n, b0.if_empty_n};
  assign o_af      = {b1.if_almost_full, b0.if_almost_full};
  assign o_ae      = {b1.if_almost_empty, b0.if_almost_empty};
  assign o_ovf     = {b1.err_overflow, b0.err_overflow};
  assign o_unf     = {b1.err_underflow, b0.err_underflow};
  assign o_cnt[0]  = b0.if_num_data_valid;  assign o_cnt[1]  = b1.if_num_data_valid;
  assign o_dout[0] = b0.if_dout;            assign o_dout[1] = b1.if_dout;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d (OUT_REG=%0d) @%0t: got %0h want %0h", nm, k, k, $time, act, exp);
    end
  endtask

  // status word: {full_n, empty_n, almost_full, almost_empty, overflow, underflow, count[3:0]}
  function automatic logic [9:0] act_st(input int k);
    return {o_full_n[k], o_empty_n[k], o_af[k], o_ae[k], o_ovf[k], o_unf[k], o_cnt[k]};
  endfunction

  function automatic logic [9:0] exp_st(input int k, input int cnt, input bit en, input bit ov, input bit un);
    int srl_words = cnt - ((k == 1) ? int'(en) : 0);
    return {srl_words != DEPTH, en, cnt >= AF, cnt <= AE, ov, un, 4'(cnt)};
  endfunction

  // Queue-level model: a circular buffer of held words; for OUT_REG=1 the head is only
  // visible once it has been moved into the output stage (hv).
  logic [DW-1:0] mbuf [2][8];
  int            mhead [2], msize [2];
  bit            mhv [2], movf [2], munf [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      mhead[k] = 0; msize[k] = 0; mhv[k] = 0; movf[k] = 0; munf[k] = 0;
    end
  endfunction

  function automatic bit m_en(input int k);
    return (k == 1) ? mhv[k] : (msize[k] != 0);
  endfunction

  function automatic void model_step(input int k, input bit w, input bit r, input logic [DW-1:0] d);
    int  in_srl = msize[k] - ((k == 1) ? int'(mhv[k]) : 0);
    bit  fn = (in_srl != DEPTH);
    bit  en = m_en(k);
    bit  wa = w & fn, ra = r & en;
    if (w && !fn) movf[k] = 1;
    if (r && !en) munf[k] = 1;
    if (k == 1) begin
      if (in_srl > 0 && (!mhv[k] || ra)) mhv[k] = 1;
      else if (ra)                        mhv[k] = 0;
    end
    if (ra) begin mhead[k] = (mhead[k] + 1) % 8; msize[k]--; end
    if (wa) begin mbuf[k][(mhead[k] + msize[k]) % 8] = d; msize[k]++; end
  endfunction

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      chk("model_status", k, 32'(act_st(k)), 32'(exp_st(k, msize[k], m_en(k), movf[k], munf[k])));
      if (m_en(k)) chk("model_dout", k, 32'(o_dout[k]), 32'(mbuf[k][mhead[k]]));
    end
  endtask

  task automatic cyc(input bit w, input bit wce, input logic [DW-1:0] d, input bit r, input bit rce);
    write = w; write_ce = wce; din = d; read = r; read_ce = rce;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, w & wce, r & rce, d);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    write = 0; write_ce = 0; read = 0; read_ce = 0; din = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit                  w, r;
    logic [DW-1:0]       din;
    logic [1:0][3:0]     c;
    logic [1:0][DW-1:0]  d;
    logic [1:0]          e, ov, un;
  } vec_t;

  function automatic vec_t mk(input bit w, input bit r, input logic [7:0] di,
                              input int c0, input int c1, input logic [7:0] d0, input logic [7:0] d1,
                              input bit e0, input bit e1, input bit ov0, input bit ov1,
                              input bit un0, input bit un1);
    vec_t v;
    v.w = w; v.r = r; v.din = di;
    v.c = {4'(c1), 4'(c0)}; v.d = {d1, d0};
    v.e = {e1, e0}; v.ov = {ov1, ov0}; v.un = {un1, un0};
    return v;
  endfunction

  vec_t tbl [12];

  initial begin
    // Fill past capacity (OUT_REG=0 holds 4, OUT_REG=1 holds 5), then drain past empty.
    tbl[0]  = mk(1, 0, 8'h01, 1, 1, 8'h01, 8'h00, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 8'h02, 2, 2, 8'h01, 8'h01, 1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 8'h03, 3, 3, 8'h01, 8'h01, 1, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 8'h04, 4, 4, 8'h01, 8'h01, 1, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 8'h05, 4, 5, 8'h01, 8'h01, 1, 1, 1, 0, 0, 0);
    tbl[5]  = mk(1, 0, 8'h06, 4, 5, 8'h01, 8'h01, 1, 1, 1, 1, 0, 0);
    tbl[6]  = mk(0, 1, 8'h00, 3, 4, 8'h02, 8'h02, 1, 1, 1, 1, 0, 0);
    tbl[7]  = mk(0, 1, 8'h00, 2, 3, 8'h03, 8'h03, 1, 1, 1, 1, 0, 0);
    tbl[8]  = mk(0, 1, 8'h00, 1, 2, 8'h04, 8'h04, 1, 1, 1, 1, 0, 0);
    tbl[9]  = mk(0, 1, 8'h00, 0, 1, 8'h00, 8'h05, 0, 1, 1, 1, 0, 0);
    tbl[10] = mk(0, 1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 1, 0);
    tbl[11] = mk(0, 1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 1, 1);

    do_reset();
    for (int k = 0; k < 2; k++) chk("reset_state", k, 32'(act_st(k)), 32'(10'b1001_00_0000));

    // Single write: head latency 1 vs 2 cycles.
    cyc(1, 1, 8'h11, 0, 0);
    chk("wr_lat1_empty_n", 0, 32'(o_empty_n[0]), 32'd1);
    chk("wr_lat1_empty_n", 1, 32'(o_empty_n[1]), 32'd0);
    cyc(0, 0, 8'h00, 0, 0);
    for (int k = 0; k < 2; k++) begin
      chk("wr_lat2_empty_n", k, 32'(o_empty_n[k]), 32'd1);
      chk("wr_dout_11", k, 32'(o_dout[k]), 32'h11);
      chk("wr_count_1", k, 32'(o_cnt[k]), 32'd1);
    end

    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].w, 1, tbl[i].din, tbl[i].r, 1);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tbl%0d_status", i), k, 32'(act_st(k)),
            32'(exp_st(k, int'(tbl[i].c[k]), tbl[i].e[k], tbl[i].ov[k], tbl[i].un[k])));
        if (tbl[i].e[k]) chk($sformatf("tbl%0d_dout", i), k, 32'(o_dout[k]), 32'(tbl[i].d[k]));
      end
    end

    // Underflow and overflow stay set through idle cycles.
    repeat (3) cyc(0, 0, 8'h00, 0, 0);
    for (int k = 0; k < 2; k++) begin
      chk("sticky_unf", k, 32'(o_unf[k]), 32'd1);
      chk("sticky_ovf", k, 32'(o_ovf[k]), 32'd1);
    end

    // Async reset mid-cycle with 3 words held and both error flags set.
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'(8'h30 + i), 0, 0);
    write = 0; write_ce = 0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk("async_reset", k, 32'(act_st(k)), 32'(10'b1001_00_0000));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 1, 8'hAA, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    for (int k = 0; k < 2; k++) chk("post_reset_dout", k, 32'(o_dout[k]), 32'hAA);
    cyc(0, 0, 8'h00, 1, 1);

    // Steady write+read at count 2.
    cyc(1, 1, 8'h20, 0, 0);
    cyc(1, 1, 8'h21, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 8'(8'h22 + i), 1, 1);
      for (int k = 0; k < 2; k++) chk("wrrd_count", k, 32'(o_cnt[k]), 32'd2);
    end

    // Random traffic, alternating fill-biased and drain-biased phases.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      int wp = ((i / 300) % 2 == 1) ? 75 : 25;
      cyc(($urandom % 100) < wp, ($urandom % 8) != 0, 8'($urandom),
          ($urandom % 100) < (100 - wp), ($urandom % 8) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
